// File: rtl/sal_cmd_scheduler.sv
// sal_cmd_scheduler
//   Channel-level DDR2 command scheduler. Collects ACT/RD/WR/PRE/REF requests
//   from NUM_BANKS bank controllers and grants at most one per cycle.
//   Class priority is REF > CAS (RD/WR) > ACT > PRE. Within a class, banks are
//   served round-robin from rr_ptr. Inter-bank timing (tRRD, tCCD, tWTR, tRTW)
//   is enforced by three down-counters. The winning command and its payload
//   are registered for the DRAM command/address driver.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   act/rd/wr/pre/ref_req_i [N]     per-bank requests
//   ra_i/ca_i/id_i/len_i/seq_num_i  per-bank payload, bank b at [b*W +: W]
//   trrd_i/tccd_i/twtr_i/trtw_i     timing in cycles (quasi-static)
//   act/rd/wr/pre/ref_gnt_o [N]     per-bank grants (combinational, one-hot overall)
//   cmd_valid_o, cmd_o, cmd_bank_o  registered command (0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 REF)
//   cmd_ra/ca/id/len/seq_o          registered payload of the granted bank
module sal_cmd_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 14,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int SEQ_W     = 8,
  parameter int CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          act_req_i,
  input  logic [NUM_BANKS-1:0]          rd_req_i,
  input  logic [NUM_BANKS-1:0]          wr_req_i,
  input  logic [NUM_BANKS-1:0]          pre_req_i,
  input  logic [NUM_BANKS-1:0]          ref_req_i,
  input  logic [NUM_BANKS*RA_W-1:0]     ra_i,
  input  logic [NUM_BANKS*CA_W-1:0]     ca_i,
  input  logic [NUM_BANKS*ID_W-1:0]     id_i,
  input  logic [NUM_BANKS*LEN_W-1:0]    len_i,
  input  logic [NUM_BANKS*SEQ_W-1:0]    seq_num_i,
  input  logic [CNT_W-1:0]              trrd_i,
  input  logic [CNT_W-1:0]              tccd_i,
  input  logic [CNT_W-1:0]              twtr_i,
  input  logic [CNT_W-1:0]              trtw_i,
  output logic [NUM_BANKS-1:0]          act_gnt_o,
  output logic [NUM_BANKS-1:0]          rd_gnt_o,
  output logic [NUM_BANKS-1:0]          wr_gnt_o,
  output logic [NUM_BANKS-1:0]          pre_gnt_o,
  output logic [NUM_BANKS-1:0]          ref_gnt_o,
  output logic                          cmd_valid_o,
  output logic [2:0]                    cmd_o,
  output logic [$clog2(NUM_BANKS)-1:0]  cmd_bank_o,
  output logic [RA_W-1:0]               cmd_ra_o,
  output logic [CA_W-1:0]               cmd_ca_o,
  output logic [ID_W-1:0]               cmd_id_o,
  output logic [LEN_W-1:0]              cmd_len_o,
  output logic [SEQ_W-1:0]              cmd_seq_o
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  // Round-robin pick: returns {hit, bank}. Scanning offsets from high to low
  // leaves the smallest offset from ptr as the final assignment. Bank index
  // arithmetic wraps naturally because NUM_BANKS is a power of two.
  function automatic logic [BANK_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                               input logic [BANK_W-1:0]    ptr);
    logic [BANK_W:0]   res;
    logic [BANK_W-1:0] idx;
    res = '0;
    for (int unsigned i = NUM_BANKS; i > 0; i--) begin
      idx = ptr + BANK_W'(i - 1);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CNT_W-1:0]  cnt_act, cnt_rd, cnt_wr;
  logic [CNT_W-1:0]  cnt_act_nxt, cnt_rd_nxt, cnt_wr_nxt;
  logic [BANK_W-1:0] rr_ptr;

  logic [NUM_BANKS-1:0] rd_elig, wr_elig, cas_elig, act_elig;
  logic [BANK_W:0]      ref_pick, cas_pick, act_pick, pre_pick;

  logic              gnt_any;
  cmd_e              gnt_cmd;
  logic [BANK_W-1:0] gnt_bank;

  logic [RA_W-1:0]  sel_ra;
  logic [CA_W-1:0]  sel_ca;
  logic [ID_W-1:0]  sel_id;
  logic [LEN_W-1:0] sel_len;
  logic [SEQ_W-1:0] sel_seq;

  cmd_e cmd_q;

  assign rd_elig  = rd_req_i  & {NUM_BANKS{cnt_rd  == '0}};
  assign wr_elig  = wr_req_i  & {NUM_BANKS{cnt_wr  == '0}};
  assign act_elig = act_req_i & {NUM_BANKS{cnt_act == '0}};
  // A bank whose RD is timing-blocked may still offer an eligible WR.
  assign cas_elig = rd_elig | wr_elig;

  assign ref_pick = rr_pick(ref_req_i, rr_ptr);
  assign cas_pick = rr_pick(cas_elig,  rr_ptr);
  assign act_pick = rr_pick(act_elig,  rr_ptr);
  assign pre_pick = rr_pick(pre_req_i, rr_ptr);

  // Grant arbitration
  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    gnt_any   = 1'b0;
    gnt_cmd   = CMD_NOP;
    gnt_bank  = '0;
    if (!rst) begin
      if (ref_pick[BANK_W]) begin
        gnt_any  = 1'b1;
        gnt_cmd  = CMD_REF;
        gnt_bank = ref_pick[BANK_W-1:0];
        ref_gnt_o[gnt_bank] = 1'b1;
      end else if (cas_pick[BANK_W]) begin
        gnt_any  = 1'b1;
        gnt_bank = cas_pick[BANK_W-1:0];
        if (rd_elig[gnt_bank]) begin
          gnt_cmd = CMD_RD;
          rd_gnt_o[gnt_bank] = 1'b1;
        end else begin
          gnt_cmd = CMD_WR;
          wr_gnt_o[gnt_bank] = 1'b1;
        end
      end else if (act_pick[BANK_W]) begin
        gnt_any  = 1'b1;
        gnt_cmd  = CMD_ACT;
        gnt_bank = act_pick[BANK_W-1:0];
        act_gnt_o[gnt_bank] = 1'b1;
      end else if (pre_pick[BANK_W]) begin
        gnt_any  = 1'b1;
        gnt_cmd  = CMD_PRE;
        gnt_bank = pre_pick[BANK_W-1:0];
        pre_gnt_o[gnt_bank] = 1'b1;
      end
    end
  end

  // Timing counters: decrement with saturation; a grant loads v-1 but never
  // shortens a counter that is already further out.
  always_comb begin
    cnt_act_nxt = dec_sat(cnt_act);
    cnt_rd_nxt  = dec_sat(cnt_rd);
    cnt_wr_nxt  = dec_sat(cnt_wr);
    case (gnt_cmd)
      CMD_ACT: cnt_act_nxt = umax(dec_sat(trrd_i), cnt_act_nxt);
      CMD_RD: begin
        cnt_rd_nxt = umax(dec_sat(tccd_i), cnt_rd_nxt);
        cnt_wr_nxt = umax(dec_sat(umax(tccd_i, trtw_i)), cnt_wr_nxt);
      end
      CMD_WR: begin
        cnt_wr_nxt = umax(dec_sat(tccd_i), cnt_wr_nxt);
        cnt_rd_nxt = umax(dec_sat(umax(tccd_i, twtr_i)), cnt_rd_nxt);
      end
      default: ;
    endcase
  end

  // Payload mux for the granted bank
  always_comb begin
    sel_ra  = '0;
    sel_ca  = '0;
    sel_id  = '0;
    sel_len = '0;
    sel_seq = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (gnt_bank == BANK_W'(b)) begin
        sel_ra  = ra_i[b*RA_W +: RA_W];
        sel_ca  = ca_i[b*CA_W +: CA_W];
        sel_id  = id_i[b*ID_W +: ID_W];
        sel_len = len_i[b*LEN_W +: LEN_W];
        sel_seq = seq_num_i[b*SEQ_W +: SEQ_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_act     <= '0;
      cnt_rd      <= '0;
      cnt_wr      <= '0;
      rr_ptr      <= '0;
      cmd_valid_o <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_bank_o  <= '0;
      cmd_ra_o    <= '0;
      cmd_ca_o    <= '0;
      cmd_id_o    <= '0;
      cmd_len_o   <= '0;
      cmd_seq_o   <= '0;
    end else begin
      cnt_act     <= cnt_act_nxt;
      cnt_rd      <= cnt_rd_nxt;
      cnt_wr      <= cnt_wr_nxt;
      cmd_valid_o <= gnt_any;
      cmd_q       <= gnt_cmd;
      if (gnt_any) begin
        rr_ptr     <= gnt_bank + 1'b1;
        cmd_bank_o <= gnt_bank;
        cmd_ra_o   <= sel_ra;
        cmd_ca_o   <= sel_ca;
        cmd_id_o   <= sel_id;
        cmd_len_o  <= sel_len;
        cmd_seq_o  <= sel_seq;
      end else begin
        cmd_bank_o <= '0;
        cmd_ra_o   <= '0;
        cmd_ca_o   <= '0;
        cmd_id_o   <= '0;
        cmd_len_o  <= '0;
        cmd_seq_o  <= '0;
      end
    end
  end

  assign cmd_o = cmd_q;

endmodule

// File: tb/tb_sal_cmd_scheduler.sv
// tb_sal_cmd_scheduler
//   Self-checking bench for sal_cmd_scheduler. A behavioural model (integer
//   counters, scan of classes in priority order, modulo round-robin) predicts
//   grants each cycle and the registered command one cycle later. Directed
//   scenarios pin the model with hand-computed values, then random traffic runs.
module tb_sal_cmd_scheduler;
  localparam int N = 4, RA_W = 14, CA_W = 10, ID_W = 4, LEN_W = 4, SEQ_W = 8;
  localparam int CNT_W = 4, BW = 2;

  logic clk, rst;
  logic [N-1:0] act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i;
  logic [N*RA_W-1:0] ra_i;
  logic [N*CA_W-1:0] ca_i;
  logic [N*ID_W-1:0] id_i;
  logic [N*LEN_W-1:0] len_i;
  logic [N*SEQ_W-1:0] seq_num_i;
  logic [CNT_W-1:0] trrd_i, tccd_i, twtr_i, trtw_i;
  logic [N-1:0] act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
  logic cmd_valid_o;
  logic [2:0] cmd_o;
  logic [BW-1:0] cmd_bank_o;
  logic [RA_W-1:0] cmd_ra_o;
  logic [CA_W-1:0] cmd_ca_o;
  logic [ID_W-1:0] cmd_id_o;
  logic [LEN_W-1:0] cmd_len_o;
  logic [SEQ_W-1:0] cmd_seq_o;

  sal_cmd_scheduler #(.NUM_BANKS(N), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W),
                      .LEN_W(LEN_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .act_req_i(act_req_i), .rd_req_i(rd_req_i), .wr_req_i(wr_req_i),
    .pre_req_i(pre_req_i), .ref_req_i(ref_req_i),
    .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i), .seq_num_i(seq_num_i),
    .trrd_i(trrd_i), .tccd_i(tccd_i), .twtr_i(twtr_i), .trtw_i(trtw_i),
    .act_gnt_o(act_gnt_o), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o),
    .pre_gnt_o(pre_gnt_o), .ref_gnt_o(ref_gnt_o),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_bank_o(cmd_bank_o),
    .cmd_ra_o(cmd_ra_o), .cmd_ca_o(cmd_ca_o), .cmd_id_o(cmd_id_o),
    .cmd_len_o(cmd_len_o), .cmd_seq_o(cmd_seq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_rr = 0, c_act = 0, c_rd = 0, c_wr = 0;
  int w_cmd = 0, w_bank = 0;                 // this cycle's predicted winner
  logic [RA_W-1:0] w_ra; logic [CA_W-1:0] w_ca; logic [ID_W-1:0] w_id;
  logic [LEN_W-1:0] w_len; logic [SEQ_W-1:0] w_seq;
  int e_cmd = 0, e_bank = 0;                 // expected registered command
  logic e_valid = 1'b0;
  logic [RA_W-1:0] e_ra = '0; logic [CA_W-1:0] e_ca = '0; logic [ID_W-1:0] e_id = '0;
  logic [LEN_W-1:0] e_len = '0; logic [SEQ_W-1:0] e_seq = '0;
  logic started = 1'b0;

  function automatic int ld(input int v);
    return (v == 0) ? 0 : v - 1;
  endfunction
  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Compare process: predict at negedge, compare every cycle.
  always @(negedge clk) begin
    logic [N-1:0] g_ref, g_rd, g_wr, g_act, g_pre;
    int b;
    w_cmd = 0; w_bank = 0;
    g_ref = '0; g_rd = '0; g_wr = '0; g_act = '0; g_pre = '0;
    if (!rst) begin
      // classes in priority order: 0 REF, 1 CAS, 2 ACT, 3 PRE
      for (int cls = 0; cls < 4; cls++) begin
        for (int k = 0; k < N; k++) begin
          b = (m_rr + k) % N;
          if (w_cmd == 0) begin
            case (cls)
              0: if (ref_req_i[b]) w_cmd = 5;
              1: if (rd_req_i[b] && c_rd == 0) w_cmd = 2;
                 else if (wr_req_i[b] && c_wr == 0) w_cmd = 3;
              2: if (act_req_i[b] && c_act == 0) w_cmd = 1;
              default: if (pre_req_i[b]) w_cmd = 4;
            endcase
            if (w_cmd != 0) w_bank = b;
          end
        end
      end
    end
    case (w_cmd)
      1: g_act[w_bank] = 1'b1;
      2: g_rd[w_bank] = 1'b1;
      3: g_wr[w_bank] = 1'b1;
      4: g_pre[w_bank] = 1'b1;
      5: g_ref[w_bank] = 1'b1;
      default: ;
    endcase
    w_ra  = ra_i[w_bank*RA_W +: RA_W];
    w_ca  = ca_i[w_bank*CA_W +: CA_W];
    w_id  = id_i[w_bank*ID_W +: ID_W];
    w_len = len_i[w_bank*LEN_W +: LEN_W];
    w_seq = seq_num_i[w_bank*SEQ_W +: SEQ_W];
    if (started) begin
      chk("ref_gnt", ref_gnt_o, g_ref);
      chk("rd_gnt", rd_gnt_o, g_rd);
      chk("wr_gnt", wr_gnt_o, g_wr);
      chk("act_gnt", act_gnt_o, g_act);
      chk("pre_gnt", pre_gnt_o, g_pre);
      chk("cmd_valid", cmd_valid_o, e_valid);
      chk("cmd", cmd_o, e_cmd);
      chk("cmd_bank", cmd_bank_o, e_bank);
      chk("cmd_payload", {cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o, cmd_seq_o},
          {e_ra, e_ca, e_id, e_len, e_seq});
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_rr = 0; c_act = 0; c_rd = 0; c_wr = 0;
      e_valid = 1'b0; e_cmd = 0; e_bank = 0;
      e_ra = '0; e_ca = '0; e_id = '0; e_len = '0; e_seq = '0;
    end else begin
      e_valid = (w_cmd != 0);
      e_cmd   = w_cmd;
      e_bank  = (w_cmd != 0) ? w_bank : 0;
      e_ra  = (w_cmd != 0) ? w_ra  : '0;
      e_ca  = (w_cmd != 0) ? w_ca  : '0;
      e_id  = (w_cmd != 0) ? w_id  : '0;
      e_len = (w_cmd != 0) ? w_len : '0;
      e_seq = (w_cmd != 0) ? w_seq : '0;
      c_act = mx(c_act - 1, 0);
      c_rd  = mx(c_rd - 1, 0);
      c_wr  = mx(c_wr - 1, 0);
      case (w_cmd)
        1: c_act = mx(ld(int'(trrd_i)), c_act);
        2: begin
          c_rd = mx(ld(int'(tccd_i)), c_rd);
          c_wr = mx(ld(mx(int'(tccd_i), int'(trtw_i))), c_wr);
        end
        3: begin
          c_wr = mx(ld(int'(tccd_i)), c_wr);
          c_rd = mx(ld(mx(int'(tccd_i), int'(twtr_i))), c_rd);
        end
        default: ;
      endcase
      if (w_cmd != 0) m_rr = (w_bank + 1) % N;
    end
    started = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    act_req_i = '1; rd_req_i = '1; wr_req_i = '1; pre_req_i = '1; ref_req_i = '1;
    ra_i = '0; ca_i = '0; id_i = '0; len_i = '0; seq_num_i = '0;
    trrd_i = 4'd0; tccd_i = 4'd2; twtr_i = 4'd4; trtw_i = 4'd0;

    // 1: reset held with all requests high
    repeat (2) begin
      tick(); #1;
      chk("rst_grants", {ref_gnt_o, rd_gnt_o, wr_gnt_o, act_gnt_o, pre_gnt_o}, '0);
      chk("rst_valid", cmd_valid_o, 1'b0);
    end
    tick(); rst = 1'b0; #1;
    chk("t1_ref_gnt", ref_gnt_o, 4'b0001);
    chk("t1_no_cas", {rd_gnt_o, wr_gnt_o}, '0);
    tick();
    act_req_i = '0; rd_req_i = '0; wr_req_i = '0; pre_req_i = '0; ref_req_i = '0; #1;
    chk("t1_cmd", {cmd_valid_o, cmd_o, cmd_bank_o}, {1'b1, 3'd5, 2'd0});

    // 2: two reads, tccd=2, rr_ptr cleared by a reset pulse
    rst = 1'b1; tick(); rst = 1'b0;
    rd_req_i = 4'b0101; #1;
    chk("t2_rd_b0", rd_gnt_o, 4'b0001);
    tick(); rd_req_i = 4'b0100; #1;
    chk("t2_gap", rd_gnt_o, 4'b0000);
    chk("t2_cmd", {cmd_valid_o, cmd_o, cmd_bank_o}, {1'b1, 3'd2, 2'd0});
    tick(); #1;
    chk("t2_rd_b2", rd_gnt_o, 4'b0100);
    tick(); rd_req_i = '0;

    // 3: CAS beats ACT in the same cycle, ACT follows
    tick(); act_req_i = 4'b0010; rd_req_i = 4'b1000; #1;
    chk("t3_rd_b3", rd_gnt_o, 4'b1000);
    chk("t3_act_wait", act_gnt_o, 4'b0000);
    tick(); rd_req_i = '0; #1;
    chk("t3_act_b1", act_gnt_o, 4'b0010);

    // 4: write-to-read turnaround, twtr=4
    tick(); act_req_i = '0; wr_req_i = 4'b0001; #1;
    chk("t4_wr_b0", wr_gnt_o, 4'b0001);
    for (int k = 1; k < 4; k++) begin
      tick(); wr_req_i = '0; rd_req_i = 4'b0010; #1;
      chk("t4_rd_blocked", rd_gnt_o, 4'b0000);
    end
    tick(); #1;
    chk("t4_rd_b1", rd_gnt_o, 4'b0010);
    tick(); rd_req_i = '0;

    // 5: held PRE requests rotate round-robin from bank 0
    rst = 1'b1; tick(); rst = 1'b0;
    pre_req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] exp_pre;
      exp_pre = 4'b0001 << (i % 4);
      #1 chk("t5_pre_rr", pre_gnt_o, exp_pre);
      tick();
    end
    pre_req_i = '0;

    // 6: reset while cnt_rd=3, then an immediate read with payload
    tccd_i = 4'd4; rd_req_i = 4'b0001; #1;
    chk("t6_rd_b0", rd_gnt_o, 4'b0001);
    tick(); rd_req_i = '0; rst = 1'b1;
    tick(); rst = 1'b0; rd_req_i = 4'b0100; ra_i[2*RA_W +: RA_W] = 14'h1A5; #1;
    chk("t6_rd_b2", rd_gnt_o, 4'b0100);
    tick(); rd_req_i = '0; #1;
    chk("t6_cmd", {cmd_valid_o, cmd_o, cmd_bank_o}, {1'b1, 3'd2, 2'd2});
    chk("t6_ra", cmd_ra_o, 14'h1A5);

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int b = 0; b < N; b++) begin
        act_req_i[b] = ($urandom_range(0, 3) == 0);
        rd_req_i[b]  = ($urandom_range(0, 3) == 0);
        wr_req_i[b]  = ($urandom_range(0, 3) == 0);
        pre_req_i[b] = ($urandom_range(0, 3) == 0);
        ref_req_i[b] = ($urandom_range(0, 15) == 0);
      end
      for (int b = 0; b < N; b++) begin
        ra_i[b*RA_W +: RA_W]        = RA_W'($urandom);
        ca_i[b*CA_W +: CA_W]        = CA_W'($urandom);
        id_i[b*ID_W +: ID_W]        = ID_W'($urandom);
        len_i[b*LEN_W +: LEN_W]     = LEN_W'($urandom);
        seq_num_i[b*SEQ_W +: SEQ_W] = SEQ_W'($urandom);
      end
      if (cyc % 250 == 0) begin
        trrd_i = CNT_W'($urandom_range(0, 15));
        tccd_i = CNT_W'($urandom_range(0, 15));
        twtr_i = CNT_W'($urandom_range(0, 15));
        trtw_i = CNT_W'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 149) == 0);
    end
    tick();
    rst = 1'b0;
    act_req_i = '0; rd_req_i = '0; wr_req_i = '0; pre_req_i = '0; ref_req_i = '0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
